// File: rtl/ddr_readout_ctrl_if.sv
// ddr_readout_ctrl_if: bundles the host control, DDR read port and output byte stream of
// ddr_readout_ctrl.
//   master modport: the readout controller (drives busy/done/error, DDR request/FIFO strobe,
//                   out_data/out_valid).
//   slave modport : the surroundings (host start/abort, DDR block, USB consumer).
// ADDR_W / CNT_W must match the parameters of the controller instance.
interface ddr_readout_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) ();
  // Host control
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  byte_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic              error;
  // DDR read port
  logic              ddr_read_req;
  logic [ADDR_W-1:0] ddr_read_address;
  logic              ddr_read_done;
  logic              ddr_read_fifoen;
  logic              ddr_read_fifoempty;
  logic [7:0]        ddr_read_data;
  // Output byte stream
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, start_addr, byte_count, abort,
    input  ddr_read_done, ddr_read_fifoempty, ddr_read_data,
    input  out_ready,
    output busy, done, error,
    output ddr_read_req, ddr_read_address, ddr_read_fifoen,
    output out_data, out_valid
  );

  modport slave (
    output start, start_addr, byte_count, abort,
    output ddr_read_done, ddr_read_fifoempty, ddr_read_data,
    output out_ready,
    input  busy, done, error,
    input  ddr_read_req, ddr_read_address, ddr_read_fifoen,
    input  out_data, out_valid
  );
endinterface

// File: rtl/ddr_readout_ctrl.sv
// ddr_readout_ctrl: turns a host readout request (start address, byte count) into a sequence of
// BURST_BYTES DDR read bursts and drains the DDR byte FIFO into a valid/ready byte stream.
// Ports:
//   clk      system clock, also the DDR read FIFO read clock
//   reset_n  asynchronous active-low reset
//   ctrl_io  ddr_readout_ctrl_if.master: start/start_addr/byte_count/abort in, busy/done/error
//            out; ddr_read_req/address/fifoen out, ddr_read_done/fifoempty/data in;
//            out_data/out_valid out, out_ready in.
module ddr_readout_ctrl #(
  parameter int unsigned BURST_BYTES = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 65535
) (
  input logic                clk,
  input logic                reset_n,
  ddr_readout_ctrl_if.master ctrl_io
);

  localparam int unsigned BlW  = $clog2(BURST_BYTES) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitDone,
    StDrain,
    StFlush,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [BlW-1:0]    burst_left_q, burst_left_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        buf0_q, buf0_d;
  logic [7:0]        buf1_q, buf1_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              in_flight_q, in_flight_d;
  logic              abort_pend_q, abort_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              req_q, req_d;

  logic              fifoen;
  logic              out_valid;
  logic              deliver;

  assign out_valid = (buf_cnt_q != 2'd0);
  assign deliver   = (state_q == StDrain) && out_valid && ctrl_io.out_ready;

  // FIFO read strobe. In DRAIN the two-entry buffer must have room for every byte already
  // requested, because data returns one cycle after the strobe.
  always_comb begin
    fifoen = 1'b0;
    if (!ctrl_io.ddr_read_fifoempty && (burst_left_q != '0)) begin
      if (state_q == StFlush) begin
        fifoen = 1'b1;
      end else if ((state_q == StDrain) && ((buf_cnt_q + {1'b0, in_flight_q}) < 2'd2)) begin
        fifoen = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    burst_left_d = burst_left_q;
    tmo_d        = tmo_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    buf_cnt_d    = buf_cnt_q;
    in_flight_d  = fifoen;
    abort_pend_d = abort_pend_q;
    error_d      = error_q;

    if (deliver) begin
      remaining_d = remaining_q - 1'b1;
    end
    if (fifoen) begin
      burst_left_d = burst_left_q - 1'b1;
    end

    // Output buffer: buf0 is the head presented on out_data, buf1 the second slot.
    if (deliver) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if ((state_q == StDrain) && in_flight_q) begin
      if (buf_cnt_d == 2'd0) begin
        buf0_d = ctrl_io.ddr_read_data;
      end else begin
        buf1_d = ctrl_io.ddr_read_data;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (ctrl_io.start) begin
          addr_d       = ctrl_io.start_addr;
          remaining_d  = ctrl_io.byte_count;
          error_d      = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (ctrl_io.byte_count == '0) ? StFin : StReq;
        end
      end
      StReq: begin
        burst_left_d = BlW'(BURST_BYTES);
        tmo_d        = '0;
        if (ctrl_io.abort) begin
          abort_pend_d = 1'b1;
        end
        state_d = StWaitDone;
      end
      StWaitDone: begin
        tmo_d = tmo_q + 1'b1;
        if (ctrl_io.abort) begin
          abort_pend_d = 1'b1;
        end
        // The burst is already committed on the DDR side, so an abort still waits for it and
        // then flushes it to leave the FIFO empty.
        if (ctrl_io.ddr_read_done) begin
          state_d = (abort_pend_q || ctrl_io.abort) ? StFlush : StDrain;
        end else if (tmo_d == TmoW'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = StFin;
        end
      end
      StDrain: begin
        if (ctrl_io.abort) begin
          state_d = StFlush;
        end else if (remaining_d == '0) begin
          // A strobe issued this cycle returns data next cycle; FLUSH absorbs it.
          state_d = ((burst_left_d != '0) || fifoen) ? StFlush : StFin;
        end else if ((burst_left_q == '0) && !in_flight_q && (buf_cnt_d == 2'd0)) begin
          addr_d  = addr_q + ADDR_W'(BURST_BYTES);
          state_d = StReq;
        end
      end
      StFlush: begin
        if ((burst_left_q == '0) && !in_flight_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Buffered bytes only survive while draining; leaving DRAIN discards them.
    if (state_d != StDrain) begin
      buf_cnt_d = 2'd0;
    end
  end

  assign busy_d = (state_d != StIdle);
  assign done_d = (state_d == StFin);
  assign req_d  = (state_d == StReq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      remaining_q  <= '0;
      burst_left_q <= '0;
      tmo_q        <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      buf_cnt_q    <= 2'd0;
      in_flight_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      burst_left_q <= burst_left_d;
      tmo_q        <= tmo_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      buf_cnt_q    <= buf_cnt_d;
      in_flight_q  <= in_flight_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      req_q        <= req_d;
    end
  end

  assign ctrl_io.busy             = busy_q;
  assign ctrl_io.done             = done_q;
  assign ctrl_io.error            = error_q;
  assign ctrl_io.ddr_read_req     = req_q;
  assign ctrl_io.ddr_read_address = addr_q;
  assign ctrl_io.ddr_read_fifoen  = fifoen;
  assign ctrl_io.out_data         = buf0_q;
  assign ctrl_io.out_valid        = out_valid;

endmodule
